// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes operation commands into MIPS words and streams them into instruction memory
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter int          AW        = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [15:0]              in_imm,
    output logic                     imem_we,
    input  logic                     imem_ready,
    output logic [AW-1:0]            imem_addr,
    output logic [31:0]              imem_wd,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     wrapped,
    output logic                     err,
    output logic [7:0]               err_cnt
);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

    logic [31:0] mem [DEPTH];
    logic [PW:0] wptr;
    logic [PW:0] rptr;
    logic [31:0] word;
    logic        legal;
    logic        full;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (in_op)
            4'd0:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            4'd1:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            4'd2:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            4'd3:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            4'd4:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            4'd5:    word = {6'b100011, in_rs, in_rt, in_imm};
            4'd6:    word = {6'b101011, in_rs, in_rt, in_imm};
            4'd7:    word = {6'b000100, in_rs, in_rt, in_imm};
            4'd8:    word = {6'b001000, in_rs, in_rt, in_imm};
            default: legal = 1'b0;
        endcase
    end

    // Pointers carry one extra bit so full and empty differ at equal indices.
    assign level    = wptr - rptr;
    assign full     = (level == (PW+1)'(DEPTH));
    assign in_ready = !full && !flush;
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign imem_we  = (level != '0);
    assign pop      = imem_we && imem_ready;
    assign imem_wd  = imem_we ? mem[rptr[PW-1:0]] : 32'h0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[PW-1:0]] <= word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            imem_addr <= BASE;
            wrapped   <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            imem_addr <= BASE;
            err       <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop) begin
                rptr      <= rptr + 1'b1;
                imem_addr <= imem_addr + 1'b1;
                if (imem_addr == '1)
                    wrapped <= 1'b1;
            end
            err <= accept && !legal;
            if (accept && !legal && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, v2, imem_ready, ready2;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;

    logic        in_ready, imem_we, wrapped, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wd;
    logic [2:0]  level;
    logic [7:0]  err_cnt;

    logic        in_ready2, imem_we2, wrapped2, err2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wd2;
    logic [2:0]  level2;
    logic [7:0]  err_cnt2;

    instr_encoder #(.DEPTH(4), .AW(6), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .level(level), .wrapped(wrapped), .err(err), .err_cnt(err_cnt)
    );

    instr_encoder #(.DEPTH(4), .AW(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(v2), .in_ready(in_ready2),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .imem_we(imem_we2), .imem_ready(ready2), .imem_addr(imem_addr2), .imem_wd(imem_wd2),
        .level(level2), .wrapped(wrapped2), .err(err2), .err_cnt(err_cnt2)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    endtask

    initial begin
        vecs[0] = '{4'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 32'h00221820};
        vecs[1] = '{4'd1, 5'd4,  5'd5,  5'd6,  16'h0000, 32'h00853022};
        vecs[2] = '{4'd5, 5'd0,  5'd8,  5'd0,  16'h0004, 32'h8C080004};
        vecs[3] = '{4'd6, 5'd29, 5'd31, 5'd0,  16'h0008, 32'hAFBF0008};
        vecs[4] = '{4'd7, 5'd1,  5'd2,  5'd0,  16'hFFFF, 32'h1022FFFF};
        vecs[5] = '{4'd8, 5'd0,  5'd2,  5'd0,  16'h0005, 32'h20020005};
        vecs[6] = '{4'd2, 5'd7,  5'd8,  5'd9,  16'hFFFF, 32'h00E84824};
        vecs[7] = '{4'd3, 5'd31, 5'd31, 5'd31, 16'h1234, 32'h03FFF825};
        vecs[8] = '{4'd4, 5'd2,  5'd3,  5'd4,  16'h0000, 32'h0043202A};
        vecs[9] = '{4'd5, 5'd3,  5'd4,  5'd31, 16'h8000, 32'h8C648000};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; v2 = 1'b0;
        imem_ready = 1'b0; ready2 = 1'b0;
        cmd(4'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        repeat (2) @(negedge clk);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_wd", imem_wd, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wrapped", 32'(wrapped), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Encoding table: one command per two cycles, each written at the next address
        imem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
            in_valid = 1'b1;
            @(negedge clk);
            chk("vec_we", 32'(imem_we), 32'd1);
            chk("vec_wd", imem_wd, vecs[i].exp);
            chk("vec_addr", 32'(imem_addr), 32'(i));
            in_valid = 1'b0;
            @(negedge clk);
            chk("vec_drained", 32'(level), 32'd0);
        end

        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_addr", 32'(imem_addr), 32'd0);

        // Stall with full FIFO, then drain in order
        imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd(4'd0, 5'd1, 5'd2, 5'(3 + k), 16'h0);
            in_valid = 1'b1;
            @(negedge clk);
            chk("fill_level", 32'(level), 32'(k + 1));
        end
        cmd(4'd0, 5'd1, 5'd2, 5'd7, 16'h0);
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("full_level", 32'(level), 32'd4);
        chk("stall_wd", imem_wd, 32'h00221820);
        chk("stall_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        chk("stall_wd_hold", imem_wd, 32'h00221820);
        imem_ready = 1'b1;
        @(negedge clk);
        chk("drain_wd1", imem_wd, 32'h00222020);
        chk("drain_lvl1", 32'(level), 32'd3);
        chk("drain_rdy1", 32'(in_ready), 32'd1);
        chk("drain_addr1", 32'(imem_addr), 32'd1);
        @(negedge clk);
        chk("drain_wd2", imem_wd, 32'h00222820);
        chk("drain_lvl2", 32'(level), 32'd3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_wd3", imem_wd, 32'h00223020);
        chk("drain_lvl3", 32'(level), 32'd2);
        @(negedge clk);
        chk("drain_wd4", imem_wd, 32'h00223820);
        chk("drain_addr4", 32'(imem_addr), 32'd4);
        @(negedge clk);
        chk("drain_we", 32'(imem_we), 32'd0);
        chk("drain_addr5", 32'(imem_addr), 32'd5);

        // Flush with level=3 at address 2
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cmd(4'd1, 5'd4, 5'd5, 5'd6, 16'h0);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_flush_addr", 32'(imem_addr), 32'd2);
        imem_ready = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_flush_level", 32'(level), 32'd3);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_we", 32'(imem_we), 32'd0);
        chk("flush_addr2", 32'(imem_addr), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_no_accept", 32'(level), 32'd0);

        // Illegal ops
        cmd(4'd12, 5'd1, 5'd2, 5'd3, 16'h0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_cnt", 32'(err_cnt), 32'd1);
        chk("ill_level", 32'(level), 32'd0);
        chk("ill_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        chk("ill_err_pulse", 32'(err), 32'd0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("ill_flush_err", 32'(err), 32'd0);
        chk("ill_flush_cnt", 32'(err_cnt), 32'd1);
        cmd(4'd15, 5'd0, 5'd0, 5'd0, 16'h0);
        in_valid = 1'b1;
        repeat (300) @(negedge clk);
        in_valid = 1'b0;
        chk("ill_saturate", 32'(err_cnt), 32'd255);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("cnt_after_flush", 32'(err_cnt), 32'd255);

        // Address wrap on the AW=2 instance
        ready2 = 1'b1;
        cmd(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
        for (int i = 0; i < 5; i++) begin
            v2 = 1'b1;
            @(negedge clk);
            chk("wrap_we", 32'(imem_we2), 32'd1);
            chk("wrap_addr", 32'(imem_addr2), 32'(i % 4));
            v2 = 1'b0;
            @(negedge clk);
            chk("wrap_flag", 32'(wrapped2), (i >= 3) ? 32'd1 : 32'd0);
        end

        // Reset mid-burst clears outputs without a clock edge
        imem_ready = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("burst_level", 32'(level), 32'd2);
        chk("burst_addr", 32'(imem_addr), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_wd", imem_wd, 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        chk("arst_errcnt", 32'(err_cnt), 32'd0);
        chk("arst_wrapped", 32'(wrapped2), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        imem_ready = 1'b1;
        cmd(4'd8, 5'd0, 5'd2, 5'd0, 16'h0005);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_addr", 32'(imem_addr), 32'd0);
        chk("post_rst_wd", imem_wd, 32'h20020005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Converts decoded operation commands (operation selector plus register and immediate fields) into 32-bit MIPS instruction words, performing the inverse mapping of the control decoder. Encoded words are buffered in a small FIFO and written sequentially into instruction memory through a stallable write port with an auto-incrementing address. It is used by the test/boot loader path to fill instruction memory before the core runs. Supported set: add, sub, and, or, slt, lw, sw, beq, addi.

Parameters:
DEPTH, 4, FIFO depth in words; power of 2, at least 2
AW, 6, instruction memory word-address width
BASE_ADDR, 0, first word address after reset or flush

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state
flush  input  1  synchronous; empties the FIFO and reloads the address
in_valid  input  1  command valid
in_ready  output  1  encoder can accept a command
in_op  input  4  0=ADD 1=SUB 2=AND 3=OR 4=SLT 5=LW 6=SW 7=BEQ 8=ADDI; 9-15 are illegal
in_rs  input  5  source register rs
in_rt  input  5  register rt
in_rd  input  5  destination register rd (R-type only)
in_imm  input  16  immediate (I-type only)
imem_we  output  1  write request; high whenever the FIFO is non-empty
imem_ready  input  1  memory accepts the write this cycle
imem_addr  output  AW  word address of the current write
imem_wd  output  32  instruction word to write
level  output  log2(DEPTH)+1  FIFO occupancy
wrapped  output  1  sticky; set when the address wraps from 2^AW-1 to 0
err  output  1  one-cycle pulse, the cycle after an illegal op is accepted
err_cnt  output  8  count of illegal ops; saturates at 255

Behaviour:
- Reset, asynchronous: FIFO empty, imem_addr=BASE_ADDR, imem_we=0, imem_wd=0, level=0, wrapped=0, err=0, err_cnt=0. in_ready=1 once reset deasserts.
- R-type encoding (ops 0-4): {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - in_imm is ignored.
- I-type encoding (ops 5-8): {opcode, rs, rt, imm}.
  - opcode: LW 100011, SW 101011, BEQ 000100, ADDI 001000.
  - in_rd is ignored. The immediate is passed through unmodified; no sign handling.
- Accept condition: in_valid && in_ready. in_ready = !full && !flush.
  - A full FIFO does not accept a push in the same cycle as a pop.
- Legal accepted op: encoded word is pushed and appears at imem_wd and imem_we on the next cycle when the FIFO was empty (1-cycle latency).
- Illegal accepted op (9-15): handshake completes, nothing is pushed, err pulses high the next cycle, err_cnt increments unless already 255.
- Output side: imem_wd is the FIFO head, and imem_we = (level != 0).
  - On imem_we && imem_ready: pop the FIFO and set imem_addr = imem_addr + 1 modulo 2^AW.
  - On wrap to 0, wrapped is set and stays set until reset.
  - imem_wd and imem_addr stay stable while imem_we=1 and imem_ready=0.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, order preserved.
- Push into empty FIFO with imem_ready=1: the word is written on the next cycle, not the same cycle.
- Flush has priority over push, pop and illegal-op detection.
  - Next cycle: level=0, imem_we=0, imem_addr=BASE_ADDR.
  - wrapped and err_cnt are preserved.
  - The cycle-0 command is not accepted.
- Reset mid-burst: pending words are discarded; after release, writes restart at BASE_ADDR.
- Pointer widths are log2(DEPTH) plus an extra bit for the full/empty distinction.

Test Plan:
- ADD rs=1 rt=2 rd=3, then SUB rs=4 rt=5 rd=6, imem_ready=1 -> writes 0x00221820 @0, 0x00853022 @1; first imem_we one cycle after accept.
- LW rs=0 rt=8 imm=4; SW rs=29 rt=31 imm=8; BEQ rs=1 rt=2 imm=0xFFFF; ADDI rs=0 rt=2 imm=5 -> 0x8C080004, 0xAFBF0008, 0x1022FFFF, 0x20020005 at addr 0-3.
- imem_ready=0 with 5 commands offered (DEPTH=4) -> level=4, in_ready=0 on the 5th until a pop; imem_wd holds 0x00221820 stable; raising imem_ready drains in order.
- in_op=12 accepted -> no write, err pulse 1 cycle, err_cnt=1; 300 illegal ops -> err_cnt=255.
- AW=2 with 5 writes -> addresses 0,1,2,3,0; wrapped=1 after the 4th write.
- Flush with level=3 at imem_addr=2 -> next cycle level=0, imem_we=0, imem_addr=0; reset asserted mid-burst -> all outputs return to reset values immediately, without waiting for a clock edge.
